// File: rtl/jam_pkg.sv
// jam_pkg: shared types and helpers for the jam_search exhaustive
// job-assignment engine.
//   jam_state_t : controller states (IDLE, LOAD, DRAIN, EVAL, DONE)
//   job_t       : 3-bit job / worker index
//   MAXN        : largest supported problem size (cache is sized to this)
//   JAM_CW      : default cost word width
//   SW          : permutation-sum width for the default cost width
//   fact()      : constant factorial, used for latency arithmetic
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } jam_state_t;

  typedef logic [2:0] job_t;

  localparam int MAXN   = 8;
  localparam int JAM_CW = 7;
  // Eight CW-bit terms always fit in CW+3 bits, so the sum never overflows.
  localparam int SW     = JAM_CW + 3;

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int k = 2; k <= n; k++) begin
      r = r * k;
    end
    return r;
  endfunction

endpackage

// File: rtl/jam_perm_next.sv
// jam_perm_next: combinational next-lexicographic permutation of N job
// fields. Field 0 is the most significant position of the ordering, so the
// identity (0,1,..,N-1) is first and the descending order is last.
//   perm_i : current permutation, field i in bits [3i+2:3i]
//   next_o : lexicographic successor (don't-care when last_o is high)
//   last_o : perm_i is in descending order, no successor exists
module jam_perm_next
  import jam_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [3*N-1:0] perm_i,
  output logic [3*N-1:0] next_o,
  output logic           last_o
);

  // Classic pivot / successor / suffix-reversal step. All array accesses
  // use loop constants and compare against the found positions, so the
  // logic unrolls into plain muxes with no variable indexing.
  always_comb begin
    job_t a  [N];
    job_t sw [N];
    int   pivot;
    int   succ;
    job_t pivotVal;
    job_t succVal;
    logic found;

    for (int k = 0; k < N; k++) begin
      a[k] = perm_i[3*k +: 3];
    end

    // Rightmost position whose value is smaller than its right neighbour.
    found = 1'b0;
    pivot = 0;
    for (int k = 0; k < N - 1; k++) begin
      if (a[k] < a[k+1]) begin
        found = 1'b1;
        pivot = k;
      end
    end

    pivotVal = '0;
    for (int k = 0; k < N; k++) begin
      if (k == pivot) pivotVal = a[k];
    end

    // The suffix is descending, so the rightmost larger value is the
    // smallest value that still exceeds the pivot.
    succ    = pivot;
    succVal = pivotVal;
    for (int k = 0; k < N; k++) begin
      if (k > pivot && a[k] > pivotVal) begin
        succ    = k;
        succVal = a[k];
      end
    end

    for (int k = 0; k < N; k++) begin
      if (k == pivot)     sw[k] = succVal;
      else if (k == succ) sw[k] = pivotVal;
      else                sw[k] = a[k];
    end

    // Reverse the suffix after the pivot to make it ascending again.
    next_o = '0;
    for (int k = 0; k < N; k++) begin
      if (k <= pivot) begin
        next_o[3*k +: 3] = sw[k];
      end else begin
        for (int m = 0; m < N; m++) begin
          if (m == N + pivot - k) next_o[3*k +: 3] = sw[m];
        end
      end
    end

    last_o = ~found;
  end

endmodule

// File: rtl/jam_search.sv
// jam_search: exhaustive N x N job-assignment engine.
// On Start it reads the whole cost matrix from an external ROM with one
// cycle of read latency into a local cache, then scores every worker->job
// permutation in lexicographic order, one per cycle, keeping the minimum
// total, how many permutations reach it, and the first one that did.
//   CLK, RST   : clock, asynchronous active-high reset
//   Start      : launches a search when sampled high in IDLE
//   W, J       : ROM worker / job address (registered)
//   Cost       : ROM data for the address of the previous cycle
//   Busy       : search in progress, including the Valid cycle
//   Valid      : one-cycle pulse when the result outputs are final
//   MinCost    : minimum permutation sum
//   MatchCount : permutations reaching MinCost, saturating
//   BestPerm   : first minimal assignment, field i = job of worker i
module jam_search
  import jam_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = JAM_CW,
  parameter int MCW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  output logic [2:0]       W,
  output logic [2:0]       J,
  input  logic [CW-1:0]    Cost,
  output logic             Busy,
  output logic             Valid,
  output logic [CW+2:0]    MinCost,
  output logic [MCW-1:0]   MatchCount,
  output logic [3*N-1:0]   BestPerm
);

  localparam int   SUMW     = CW + 3;
  localparam job_t LAST_IDX = job_t'(N - 1);

  function automatic logic [3*N-1:0] identityPerm();
    logic [3*N-1:0] p;
    for (int i = 0; i < N; i++) begin
      p[3*i +: 3] = job_t'(i);
    end
    return p;
  endfunction

  jam_state_t       state_q, state_d;
  job_t             w_q, j_q, wPrev_q, jPrev_q;
  logic             firstLoad_q;
  logic [CW-1:0]    cache_q [MAXN][MAXN];
  logic [3*N-1:0]   perm_q, perm_d, permNext;
  logic             permLast;
  logic [SUMW-1:0]  sum;
  logic [SUMW-1:0]  minRun_q, minRun_d;
  logic [MCW-1:0]   countRun_q, countRun_d;
  logic [3*N-1:0]   bestRun_q, bestRun_d;
  logic [SUMW-1:0]  minCost_q;
  logic [MCW-1:0]   matchCount_q;
  logic [3*N-1:0]   bestPerm_q;
  logic             launch;
  logic             loadEnd;
  logic             evalEnd;

  assign launch  = (state_q == IDLE) && Start;
  assign loadEnd = (w_q == LAST_IDX) && (j_q == LAST_IDX);
  assign evalEnd = (state_q == EVAL) && permLast;

  jam_perm_next #(.N(N)) u_perm_next (
    .perm_i (perm_q),
    .next_o (permNext),
    .last_o (permLast)
  );

  // Controller sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start)    state_d = LOAD;
      LOAD:    if (loadEnd)  state_d = DRAIN;
      DRAIN:                 state_d = EVAL;
      EVAL:    if (permLast) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Row-major ROM address walk. The previous address is remembered because
  // Cost always belongs to the address presented one cycle earlier; the
  // first LOAD cycle has no valid data yet, hence firstLoad_q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_q         <= '0;
      j_q         <= '0;
      wPrev_q     <= '0;
      jPrev_q     <= '0;
      firstLoad_q <= 1'b0;
    end else begin
      wPrev_q     <= w_q;
      jPrev_q     <= j_q;
      firstLoad_q <= launch;
      if (launch) begin
        w_q <= '0;
        j_q <= '0;
      end else if (state_q == LOAD && !loadEnd) begin
        if (j_q == LAST_IDX) begin
          j_q <= '0;
          w_q <= w_q + 3'd1;
        end else begin
          j_q <= j_q + 3'd1;
        end
      end
    end
  end

  // Cost cache; contents are meaningless until a LOAD/DRAIN pass fills it.
  always_ff @(posedge CLK) begin
    if ((state_q == LOAD && !firstLoad_q) || state_q == DRAIN) begin
      cache_q[wPrev_q][jPrev_q] <= Cost;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + SUMW'(cache_q[i][perm_q[3*i +: 3]]);
    end
  end

  // Running minimum / match count / first-best. A new minimum restarts the
  // count; ties only bump the count so the earliest best is kept.
  always_comb begin
    minRun_d   = minRun_q;
    countRun_d = countRun_q;
    bestRun_d  = bestRun_q;
    perm_d     = perm_q;
    if (launch) begin
      minRun_d   = '1;
      countRun_d = '0;
      bestRun_d  = '0;
      perm_d     = identityPerm();
    end else if (state_q == EVAL) begin
      if (sum < minRun_q) begin
        minRun_d   = sum;
        countRun_d = MCW'(1);
        bestRun_d  = perm_q;
      end else if (sum == minRun_q && countRun_q != '1) begin
        countRun_d = countRun_q + MCW'(1);
      end
      if (!permLast) perm_d = permNext;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      minRun_q   <= '0;
      countRun_q <= '0;
      bestRun_q  <= '0;
      perm_q     <= '0;
    end else begin
      minRun_q   <= minRun_d;
      countRun_q <= countRun_d;
      bestRun_q  <= bestRun_d;
      perm_q     <= perm_d;
    end
  end

  // Results are captured from the next-state values on the final EVAL edge
  // so they already include the last permutation and are stable while
  // Valid is high in DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      minCost_q    <= '0;
      matchCount_q <= '0;
      bestPerm_q   <= '0;
    end else if (evalEnd) begin
      minCost_q    <= minRun_d;
      matchCount_q <= countRun_d;
      bestPerm_q   <= bestRun_d;
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = (state_q != IDLE);
  assign Valid      = (state_q == DONE);
  assign MinCost    = minCost_q;
  assign MatchCount = matchCount_q;
  assign BestPerm   = bestPerm_q;

endmodule

// File: tb/tb_jam_search.sv
// tb_jam_search: scoreboard bench for jam_search.
// Four N=8 instances (three with a 16-bit count, one with an 8-bit count)
// search in parallel on fixed cost patterns; an N=3 instance runs a
// sequence of short searches including a mid-search reset, a Start pulse
// while busy, Start held through DONE and a random cost matrix.
// Expected results come from a brute-force model that walks permutations
// in lexicographic order by decoding their factorial-base rank.
module tb_jam_search;
  import jam_pkg::*;

  typedef struct {
    int          dut;
    int          minCost;
    int          count;
    logic [23:0] perm;
    int          validCyc;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst8;
  logic        rst3;
  logic [4:0]  startV;
  logic [4:0]  busyV;
  logic [4:0]  validV;
  logic [9:0]  minV  [5];
  logic [15:0] cntV  [5];
  logic [23:0] permV [5];
  logic [2:0]  w3, j3;
  logic [6:0]  cost3;
  logic [8:0]  perm3;
  int          costTab [5][8][8];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  expect_t     sbq [$];
  bit          busyAfter [5];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // N=8 instances; each has its own registered ROM model.
  for (genvar g = 0; g < 4; g++) begin : g8
    localparam int MCWG = (g == 3) ? 8 : 16;
    logic [2:0]      w, j;
    logic [6:0]      cost;
    logic [MCWG-1:0] mc;

    jam_search #(.N(8), .CW(7), .MCW(MCWG)) u_dut (
      .CLK        (clk),
      .RST        (rst8),
      .Start      (startV[g]),
      .W          (w),
      .J          (j),
      .Cost       (cost),
      .Busy       (busyV[g]),
      .Valid      (validV[g]),
      .MinCost    (minV[g]),
      .MatchCount (mc),
      .BestPerm   (permV[g])
    );

    assign cntV[g] = 16'(mc);

    always @(posedge clk) cost <= 7'(costTab[g][w][j]);
  end

  jam_search #(.N(3), .CW(7), .MCW(16)) u_dut3 (
    .CLK        (clk),
    .RST        (rst3),
    .Start      (startV[4]),
    .W          (w3),
    .J          (j3),
    .Cost       (cost3),
    .Busy       (busyV[4]),
    .Valid      (validV[4]),
    .MinCost    (minV[4]),
    .MatchCount (cntV[4]),
    .BestPerm   (perm3)
  );

  assign permV[4] = 24'(perm3);

  always @(posedge clk) cost3 <= 7'(costTab[4][w3][j3]);

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int pendingCount(input int d);
    int n;
    n = 0;
    for (int k = 0; k < sbq.size(); k++) begin
      if (sbq[k].dut == d) n++;
    end
    return n;
  endfunction

  task automatic purge(input int d);
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].dut == d) sbq.delete(k);
    end
  endtask

  task automatic modelSearch(input int d, input int n, input int satMax,
                             output int minC, output int cnt, output logic [23:0] best);
    int          rem, f, q, pick, c, s, total;
    bit          used [8];
    logic [23:0] p;
    total = fact(n);
    minC  = 32'h7fffffff;
    cnt   = 0;
    best  = '0;
    for (int idx = 0; idx < total; idx++) begin
      rem = idx;
      s   = 0;
      p   = '0;
      for (int k = 0; k < 8; k++) used[k] = 1'b0;
      for (int w = 0; w < n; w++) begin
        f    = fact(n - 1 - w);
        q    = rem / f;
        rem  = rem % f;
        pick = 0;
        c    = 0;
        for (int jj = 0; jj < n; jj++) begin
          if (!used[jj]) begin
            if (c == q) pick = jj;
            c++;
          end
        end
        used[pick]     = 1'b1;
        p[3*w +: 3]    = 3'(pick);
        s              = s + costTab[d][w][pick];
      end
      if (s < minC) begin
        minC = s;
        cnt  = 1;
        best = p;
      end else if (s == minC && cnt < satMax) begin
        cnt++;
      end
    end
  endtask

  task automatic pushExpect(input int d, input int offset);
    expect_t e;
    int      n;
    n     = (d == 4) ? 3 : 8;
    e.dut = d;
    modelSearch(d, n, (d == 3) ? 255 : 65535, e.minCost, e.count, e.perm);
    e.validCyc = cyc + offset;
    sbq.push_back(e);
  endtask

  function automatic int searchLen(input int n);
    return n * n + fact(n) + 2;
  endfunction

  // One-cycle Start pulse to the selected instances, with expectations queued.
  task automatic applyStimulus(input logic [4:0] mask);
    @(posedge clk); #2;
    for (int d = 0; d < 5; d++) begin
      if (mask[d]) pushExpect(d, searchLen((d == 4) ? 3 : 8));
    end
    startV = startV | mask;
    @(posedge clk); #2;
    startV = startV & ~mask;
    for (int d = 0; d < 5; d++) begin
      if (mask[d]) checkOutput($sformatf("busyRise%0d", d), 64'(busyV[d]), 64'd1);
    end
  endtask

  task automatic waitDone(input int d, input int budget);
    int n;
    n = 0;
    while (pendingCount(d) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (pendingCount(d) != 0) begin
      checkOutput($sformatf("timeout%0d", d), 64'(pendingCount(d)), 64'd0);
      purge(d);
    end
  endtask

  // Output monitor: pops the oldest expectation for an instance on Valid and
  // checks that Valid is a single cycle and Busy drops right after it.
  initial begin
    expect_t e;
    int      idx;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 5; d++) begin
        if (busyAfter[d]) begin
          checkOutput($sformatf("busyFall%0d", d), 64'(busyV[d]), 64'd0);
          checkOutput($sformatf("validPulse%0d", d), 64'(validV[d]), 64'd0);
          busyAfter[d] = 1'b0;
        end else if (validV[d]) begin
          idx = -1;
          for (int k = 0; k < sbq.size(); k++) begin
            if (idx < 0 && sbq[k].dut == d) idx = k;
          end
          if (idx < 0) begin
            checkOutput($sformatf("strayValid%0d", d), 64'(pendingCount(d)), 64'd1);
          end else begin
            e = sbq[idx];
            sbq.delete(idx);
            checkOutput($sformatf("minCost%0d", d),  64'(minV[d]),  64'(e.minCost));
            checkOutput($sformatf("count%0d", d),    64'(cntV[d]),  64'(e.count));
            checkOutput($sformatf("bestPerm%0d", d), 64'(permV[d]), 64'(e.perm));
            checkOutput($sformatf("latency%0d", d),  64'(cyc),      64'(e.validCyc));
            busyAfter[d] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int tbl3 [3][3];
    tbl3 = '{'{4, 2, 8}, '{4, 3, 7}, '{3, 1, 6}};
    for (int d = 0; d < 5; d++)
      for (int w = 0; w < 8; w++)
        for (int j = 0; j < 8; j++)
          costTab[d][w][j] = 0;
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        costTab[0][w][j] = 5;
        costTab[1][w][j] = (w == j) ? 0 : 100;
        costTab[2][w][j] = (j == 7 - w) ? 1 : 100;
        costTab[3][w][j] = 9;
      end
    end
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        costTab[4][w][j] = tbl3[w][j];

    rst8   = 1'b1;
    rst3   = 1'b1;
    startV = '0;
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 5; d++) begin
      checkOutput($sformatf("rstBusy%0d", d),  64'(busyV[d]),  64'd0);
      checkOutput($sformatf("rstValid%0d", d), 64'(validV[d]), 64'd0);
      checkOutput($sformatf("rstMin%0d", d),   64'(minV[d]),   64'd0);
      checkOutput($sformatf("rstCount%0d", d), 64'(cntV[d]),   64'd0);
      checkOutput($sformatf("rstPerm%0d", d),  64'(permV[d]),  64'd0);
    end
    checkOutput("rstW", 64'(w3), 64'd0);
    checkOutput("rstJ", 64'(j3), 64'd0);
    rst8 = 1'b0;
    rst3 = 1'b0;

    // Long N=8 searches run in the background while the N=3 sequence runs.
    applyStimulus(5'b01111);

    applyStimulus(5'b10000);
    waitDone(4, 100);

    // Reset in the middle of EVAL discards the search and clears outputs.
    applyStimulus(5'b10000);
    repeat (11) @(posedge clk);
    #2;
    rst3 = 1'b1;
    purge(4);
    #1;
    checkOutput("midRstBusy",  64'(busyV[4]),  64'd0);
    checkOutput("midRstValid", 64'(validV[4]), 64'd0);
    checkOutput("midRstMin",   64'(minV[4]),   64'd0);
    checkOutput("midRstCount", 64'(cntV[4]),   64'd0);
    checkOutput("midRstPerm",  64'(permV[4]),  64'd0);
    checkOutput("midRstW",     64'(w3),        64'd0);
    @(posedge clk); #2;
    rst3 = 1'b0;

    // Restart; a Start pulse during LOAD must not disturb it.
    applyStimulus(5'b10000);
    repeat (3) @(posedge clk);
    #2;
    startV[4] = 1'b1;
    @(posedge clk); #2;
    startV[4] = 1'b0;
    waitDone(4, 100);

    // Start held high through DONE relaunches on the following IDLE cycle.
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 3; j++)
        costTab[4][w][j] = $urandom_range(0, 127);
    @(posedge clk); #2;
    pushExpect(4, searchLen(3));
    pushExpect(4, 2 * searchLen(3) + 1);
    startV[4] = 1'b1;
    repeat (25) @(posedge clk);
    #2;
    startV[4] = 1'b0;
    waitDone(4, 100);

    for (int d = 0; d < 4; d++) waitDone(d, 45000);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
